cube_pow: RTL and testbench

Sequential cube unit: computes y = x³ on a 16-bit unsigned operand using a single shared shift-add multiplier, with one adder in the datapath. It is the forward counterpart of the cube-root block and shares its start/ready handshake. It serves as the round-trip checker for the root datapath (x → ∛x → cube) and as the power stage for polynomial variants. Latency is fixed and data-independent.

---
 rtl/cube_pkg.sv | 16 +
 rtl/mult_shift.sv | 60 ++++++
 rtl/cube_pow.sv | 129 ++++++++++++
 tb/tb_cube_pow.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cube_pkg.sv
// Shared width, step count and FSM encoding for the cube unit and its multiplier.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cube_pkg;

   localparam int W         = 16;
   localparam int MUL_STEPS = 16;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQ   = 2'd1,
      CUBE = 2'd2
   } state_t;

endpackage

// File: rtl/mult_shift.sv
// 16x16->32 unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
// Latency: loads on the i_start edge, then iterates on the next 16 edges; o_done is high during the last step.
// Backpressure: none; i_start always (re)loads, even while a multiply is still running.
module mult_shift
   import cube_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_start,
   input  logic [W-1:0]   i_a,      // multiplicand
   input  logic [W-1:0]   i_b,      // multiplier, consumed LSB first
   output logic           o_done,
   output logic [2*W-1:0] o_prod
);

   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] r_mcand;
   logic [W-1:0]   r_mplier;
   logic [CNT_W-1:0] r_cnt;
   logic           r_run;

   logic [2*W-1:0] w_addend;
   logic [2*W-1:0] w_sum;
   logic           w_last;

   // The one adder: current partial sum plus the multiplicand already shifted to bit i.
   assign w_addend = r_mplier[0] ? r_mcand : '0;
   assign w_sum    = r_acc + w_addend;
   assign w_last   = (r_cnt == CNT_W'(MUL_STEPS - 1));

   // Product is taken straight from the adder so the caller can use it on the final step's edge.
   assign o_done = r_run & w_last;
   assign o_prod = w_sum;

   // Load operands on start, otherwise advance one bit per cycle while running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_run    <= 1'b0;
      end else if (i_start) begin
         r_acc    <= '0;
         r_mcand  <= {{W{1'b0}}, i_a};
         r_mplier <= i_b;
         r_cnt    <= '0;
         r_run    <= 1'b1;
      end else if (r_run) begin
         r_acc    <= w_sum;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt + 1'b1;
         if (w_last) begin
            r_run <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/cube_pow.sv
// Sequential cube: y_out = x_in^3 mod 2^16 plus overflow flag, using one time-shared multiplier.
// Latency: fixed 32 cycles from accepting edge to result edge; ready pulses one cycle.
// Backpressure: start is ignored while busy; a new start is accepted in the ready cycle.
module cube_pow
   import cube_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] x_in,
   output logic [W-1:0] y_out,
   output logic         overflow,
   output logic         ready,
   output logic         busy
);

   state_t         r_state;
   state_t         w_state_nxt;

   logic [W-1:0]   r_x;
   // Only the high half of x^2 is needed after the square step: the low half
   // goes straight into the second multiply on the same edge.
   logic           r_sq_hi;
   logic [W-1:0]   r_y;
   logic           r_ovf;
   logic           r_ready;
   logic           r_busy;

   logic           w_mul_start;
   logic [W-1:0]   w_mul_a;
   logic [W-1:0]   w_mul_b;
   logic           w_mul_done;
   logic [2*W-1:0] w_prod;
   logic           w_accept;
   logic           w_sq_ld;
   logic           w_finish;

   mult_shift u_mult (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_mul_start),
      .i_a     (w_mul_a),
      .i_b     (w_mul_b),
      .o_done  (w_mul_done),
      .o_prod  (w_prod)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and multiplier sequencing: square first, then square-low times x.
   always_comb begin
      w_state_nxt = r_state;
      w_mul_start = 1'b0;
      w_mul_a     = r_x;
      w_mul_b     = r_x;
      w_accept    = 1'b0;
      w_sq_ld     = 1'b0;
      w_finish    = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_mul_start = 1'b1;
               w_mul_a     = x_in;
               w_mul_b     = x_in;
               w_state_nxt = SQ;
            end
         end
         SQ: begin
            if (w_mul_done) begin
               w_sq_ld     = 1'b1;
               w_mul_start = 1'b1;
               w_mul_a     = w_prod[W-1:0];
               w_mul_b     = r_x;
               w_state_nxt = CUBE;
            end
         end
         CUBE: begin
            if (w_mul_done) begin
               w_finish    = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Operand capture, result registers and handshake flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x     <= '0;
         r_sq_hi <= 1'b0;
         r_y     <= '0;
         r_ovf   <= 1'b0;
         r_ready <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_ready <= w_finish;
         if (w_accept) begin
            r_x    <= x_in;
            r_busy <= 1'b1;
         end else if (w_finish) begin
            r_busy <= 1'b0;
         end
         if (w_sq_ld) begin
            r_sq_hi <= |w_prod[2*W-1:W];
         end
         if (w_finish) begin
            r_y   <= w_prod[W-1:0];
            r_ovf <= r_sq_hi | (|w_prod[2*W-1:W]);
         end
      end
   end

   assign y_out    = r_y;
   assign overflow = r_ovf;
   assign ready    = r_ready;
   assign busy     = r_busy;

endmodule

// File: tb/tb_cube_pow.sv
// Scoreboard bench for cube_pow: driver pushes expected cubes, monitor pops on ready.
// Latency: each result is also checked to land exactly 32 edges after acceptance.
// Backpressure: driver waits for busy low before presenting start.
module tb_cube_pow;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] x_in;
   logic [15:0] y_out;
   logic        overflow;
   logic        ready;
   logic        busy;

   int total;
   int bad;
   int cyc;

   typedef struct {
      logic [15:0] y;
      logic        ovf;
      int          acc;
   } exp_t;

   exp_t sb[$];

   cube_pow dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .x_in     (x_in),
      .y_out    (y_out),
      .overflow (overflow),
      .ready    (ready),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer cube, result mod 2^16 and overflow when the cube reaches 2^16.
   function automatic exp_t model(input logic [15:0] x, input int acc);
      exp_t        r;
      logic [63:0] c;
      c     = 64'(x) * 64'(x) * 64'(x);
      r.y   = c[15:0];
      r.ovf = (c >= 64'd65536);
      r.acc = acc;
      return r;
   endfunction

   // Monitor: every ready pulse must match the oldest outstanding request.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && ready) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got ready with y_out=%0d, expected no ready", y_out);
         end else begin
            e = sb.pop_front();
            chk("y_out", 32'(y_out), 32'(e.y));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("busy_in_ready_cycle", 32'(busy), 32'd0);
            chk("latency", 32'(cyc - e.acc), 32'd32);
         end
      end
   end

   // Present one operand as soon as the unit is free; optionally expect a result.
   task automatic issue(input logic [15:0] x, input bit push);
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: busy still 1 after %0d cycles, expected 0", n);
      end
      start = 1'b1;
      x_in  = x;
      if (push) sb.push_back(model(x, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      x_in  = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin : stim
      int n;
      int acc;
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      start = 1'b0;
      x_in  = '0;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      chk("reset_y_out", 32'(y_out), 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_ready", 32'(ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Basic and boundary operands, back to back
      issue(16'd3, 1'b1);
      @(negedge clk);
      chk("busy_after_accept", 32'(busy), 32'd1);
      issue(16'd40, 1'b1);
      issue(16'd41, 1'b1);
      issue(16'd0, 1'b1);
      issue(16'd300, 1'b1);
      drain();

      // start held through busy with a changed operand: ignored, then accepted in ready cycle
      @(negedge clk);
      start = 1'b1;
      x_in  = 16'd5;
      sb.push_back(model(16'd5, cyc + 1));
      @(negedge clk);
      x_in = 16'd7;
      n = 0;
      while (!ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         total++;
         bad++;
         $display("FAIL held_start_ready_timeout: ready=0 after %0d cycles, expected 1", n);
      end else begin
         sb.push_back(model(16'd7, cyc + 1));
      end
      @(negedge clk);
      start = 1'b0;
      x_in  = 16'($urandom);
      drain();

      // Reset mid-operation at edge 10 of x=20
      issue(16'd20, 1'b0);
      acc = cyc;
      while (cyc < acc + 9) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_y_out", 32'(y_out), 32'd0);
      chk("midreset_overflow", 32'(overflow), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      chk("midreset_ready", 32'(ready), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      issue(16'd2, 1'b1);
      drain();

      // Random full-range operands
      for (int i = 0; i < 20; i++) begin
         issue(16'($urandom), 1'b1);
      end
      drain();

      // Exhaustive sweep of the low operand range, back to back
      for (int i = 0; i < 1024; i++) begin
         issue(16'(i), 1'b1);
      end
      drain();

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
